alu_result_fifo: RTL and testbench

//  Downstream stage of the ALU: captures every valid ALU result {alu, carry, zero}

---
 rtl/alu_result_fifo_if.sv | 25 ++
 rtl/alu_result_fifo.sv | 89 ++++++++
 tb/tb_alu_result_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the ALU result producer, the result FIFO and its consumer.
// The master drives ALU results and out_ready; the slave is the FIFO.
interface alu_result_fifo_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic [DATA_W-1:0] alu_in;
  logic              carry_in;
  logic              zero_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;
  logic              out_zero;

  modport master (
    output valid_in, alu_in, carry_in, zero_in, out_ready,
    input  out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  valid_in, alu_in, carry_in, zero_in, out_ready,
    output out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results {alu, carry, zero}. Results that
// arrive while it is full are dropped; saturating counters track accepted and dropped results.
module alu_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_result_fifo_if.slave         bus,
  input  logic                     clear_cnt,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         result_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + 2;

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [AW:0]      level_q, level_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    head;

  logic pop, push, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

  assign pop  = !empty && bus.out_ready;
  // A full FIFO that is popped in the same cycle frees the slot being written.
  assign push = bus.valid_in && (!full || pop);
  assign drop = bus.valid_in && full && !pop;

  always_comb begin
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop  ? rd_q + 1'b1 : rd_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + 1'b1;
    if (pop && !push) level_d = level_q - 1'b1;
    res_cnt_d  = push ? sat_inc(res_cnt_q)  : res_cnt_q;
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    if (clear_cnt) begin
      res_cnt_d  = '0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      res_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      res_cnt_q  <= res_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {bus.carry_in, bus.zero_in, bus.alu_in};
  end

  // Head is masked while empty so unwritten storage never reaches the consumer.
  assign head          = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign bus.out_valid = !empty;
  assign bus.out_carry = head[EW-1];
  assign bus.out_zero  = head[EW-2];
  assign bus.out_data  = head[DATA_W-1:0];

  assign level      = level_q;
  assign result_cnt = res_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed and randomized bench for alu_result_fifo against a queue-based reference model.
module tb_alu_result_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic clear_cnt;
  logic full, empty;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0] result_cnt, drop_cnt;

  alu_result_fifo_if #(.DATA_W(DATA_W)) bus ();

  alu_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clear_cnt(clear_cnt),
    .full(full), .empty(empty), .level(level),
    .result_cnt(result_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [9:0] mq[$];
  int m_res, m_drop;
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    logic [9:0] h;
    h = (mq.size() != 0) ? mq[0] : 10'h0;
    check({tag, "_valid"}, bus.out_valid, mq.size() != 0);
    check({tag, "_data"},  bus.out_data,  h[7:0]);
    check({tag, "_carry"}, bus.out_carry, h[9]);
    check({tag, "_zero"},  bus.out_zero,  h[8]);
    check({tag, "_level"}, level,  mq.size());
    check({tag, "_full"},  full,   mq.size() == DEPTH);
    check({tag, "_empty"}, empty,  mq.size() == 0);
    check({tag, "_rcnt"},  result_cnt, m_res);
    check({tag, "_dcnt"},  drop_cnt,   m_drop);
  endtask

  // One clock: apply inputs, advance the model by the handshake rules, check after the edge.
  task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c,
                      input logic z, input logic rdy, input logic clr);
    bit pop, push, drop, was_full;
    bus.valid_in = v; bus.alu_in = d; bus.carry_in = c; bus.zero_in = z;
    bus.out_ready = rdy; clear_cnt = clr;
    was_full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    push = v && (!was_full || pop);
    drop = v && was_full && !pop;
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back({c, z, d});
    if (clr) begin
      m_res = 0; m_drop = 0;
    end else begin
      if (push && m_res  < CMAX) m_res++;
      if (drop && m_drop < CMAX) m_drop++;
    end
    check_state(tag);
    bus.valid_in = 1'b0; bus.out_ready = 1'b0; clear_cnt = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear_cnt = 1'b0;
    bus.valid_in = 1'b0; bus.alu_in = '0; bus.carry_in = 1'b0; bus.zero_in = 1'b0;
    bus.out_ready = 1'b0;
    m_res = 0; m_drop = 0;
    #12;
    check_state("reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Single push appears one cycle later
    step("t1", 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_out_data", bus.out_data, 8'h3C);
    check("t1_level", level, 1);
    check("t1_rcnt", result_cnt, 1);
    step("t1_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: 10 pushes into 8 entries, then drain in order
    for (int i = 1; i <= 10; i++) step("t2_push", 1'b1, 8'(i), 1'b0, 1'(i & 1), 1'b0, 1'b0);
    check("t2_full", full, 1'b1);
    check("t2_drop", drop_cnt, 2);
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", bus.out_data, i);
      step("t2_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("t2_empty", empty, 1'b1);

    // Full FIFO pushed and popped together: no drop
    for (int i = 0; i < 8; i++) step("t3_fill", 1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b1);
    step("t3_both", 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t3_level", level, 8);
    check("t3_full", full, 1'b1);
    check("t3_nodrop", drop_cnt, 0);
    for (int i = 0; i < 8; i++) step("t3_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Streaming push+pop across pointer wrap
    step("t4_first", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step("t4_stream", 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      check("t4_level", level, 1);
    end
    step("t4_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Drop counter saturation, then clear coinciding with a drop
    for (int i = 0; i < 8; i++) step("t5_fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < CMAX + 3; i++) step("t5_drop", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_sat", drop_cnt, CMAX);
    step("t5_clr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_clr_drop", drop_cnt, 0);
    check("t5_keep_level", level, 8);
    for (int i = 0; i < 8; i++) step("t5_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++)
      step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));

    // Asynchronous reset mid-cycle with 5 stored entries
    while (mq.size() != 0) step("t6_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("t6_fill", 1'b1, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    mq.delete(); m_res = 0; m_drop = 0;
    check("t6_empty", empty, 1'b1);
    check("t6_valid", bus.out_valid, 1'b0);
    check("t6_level", level, 0);
    check("t6_rcnt", result_cnt, 0);
    check("t6_dcnt", drop_cnt, 0);
    check("t6_data", bus.out_data, 0);
    @(negedge clk); reset = 1'b1;
    step("t6_resume", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_resume_cnt", result_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
